// File: rtl/lcd_spi_pkg.sv
// Shared constants and types for the ST7735 serial receiver/decoder.
package lcd_spi_pkg;

    // ST7735 command bytes tracked by the decoder
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Bits per serial byte (the dc bit travels alongside, not in the shift path)
    localparam int unsigned BYTE_BITS = 8;

    // RGB565 field offsets within a 16-bit pixel
    localparam int unsigned RGB565_R_LSB = 11;
    localparam int unsigned RGB565_R_W   = 5;
    localparam int unsigned RGB565_G_LSB = 5;
    localparam int unsigned RGB565_G_W   = 6;
    localparam int unsigned RGB565_B_LSB = 0;
    localparam int unsigned RGB565_B_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARGS,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_SKIP
    } dec_state_e;

    // First byte on the wire is the high half of the pixel
    function automatic logic [15:0] pix_join(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/lcd_spi_shift_rx.sv
// Oversampling SPI front end: synchronisers, SCLK edge detect, 8-bit
// deserialiser, fragment detection and the {dc, byte} word strobe.
module lcd_spi_shift_rx
    import lcd_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       cs,
    input  logic       dc,
    input  logic       sclk,
    input  logic       mosi,
    output logic [8:0] rx_data,
    output logic       rx_valid,
    output logic       frag_err
);

    logic [SYNC_STAGES-1:0] cs_sync_q, dc_sync_q, sclk_sync_q, mosi_sync_q;
    logic       cs_s, dc_s, sclk_s, mosi_s, sclk_rise;

    logic       sclk_prev_q, sclk_prev_d;
    logic       armed_q, armed_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       done_q, done_d;
    logic       done_dc_q, done_dc_d;
    logic [8:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frag_q, frag_d;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign dc_s      = dc_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // Shift/count logic; reception is held off after reset until CS is seen high
    always_comb begin
        sclk_prev_d = sclk_s;
        armed_d     = armed_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        done_d      = 1'b0;
        done_dc_d   = done_dc_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frag_d      = 1'b0;

        if (cs_s) begin
            armed_d   = 1'b1;
            frag_d    = (bit_cnt_q != 3'd0);
            bit_cnt_d = 3'd0;
        end else if (sclk_rise && armed_q) begin
            shreg_d   = {shreg_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(BYTE_BITS - 1)) begin
                done_d    = 1'b1;
                done_dc_d = dc_s;
            end
        end

        if (done_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = {done_dc_q, shreg_q};
        end
    end

    // Synchroniser chains and receiver state registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cs_sync_q   <= '0;
            dc_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            done_q      <= 1'b0;
            done_dc_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frag_q      <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_prev_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            done_q      <= done_d;
            done_dc_q   <= done_dc_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frag_q      <= frag_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign frag_err = frag_q;

endmodule

// File: rtl/lcd_spi_rx.sv
// ST7735 serial receiver and command decoder: tracks CASET/RASET/RAMWR and
// reports window bounds and RGB565 pixels with their coordinates.
module lcd_spi_rx
    import lcd_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned COORD_W     = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cs,
    input  logic               dc,
    input  logic               sclk,
    input  logic               mosi,
    output logic [8:0]         rx_data,
    output logic               rx_valid,
    output logic               frag_err,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic [COORD_W-1:0] x_start,
    output logic [COORD_W-1:0] x_end,
    output logic [COORD_W-1:0] y_start,
    output logic [COORD_W-1:0] y_end,
    output logic               pix_valid,
    output logic [15:0]        pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y
);

    dec_state_e         state_q, state_d;
    logic [1:0]         arg_idx_q, arg_idx_d;
    logic [23:0]        argbuf_q, argbuf_d;
    logic [7:0]         hi_q, hi_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [7:0]         cmd_code_q, cmd_code_d;
    logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic               pix_valid_q, pix_valid_d;
    logic [15:0]        pix_data_q, pix_data_d;
    logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
    logic [15:0]        arg_start, arg_end;
    logic [7:0]         rx_byte;
    logic               rx_is_data;

    lcd_spi_shift_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_shift (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cs       (cs),
        .dc       (dc),
        .sclk     (sclk),
        .mosi     (mosi),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frag_err (frag_err)
    );

    assign rx_is_data = rx_data[8];
    assign rx_byte    = rx_data[7:0];
    assign arg_start  = argbuf_q[23:8];
    assign arg_end    = {argbuf_q[7:0], rx_byte};

    // Decoder next state, bound commits and pixel coordinate stepping
    always_comb begin
        state_d     = state_q;
        arg_idx_d   = arg_idx_q;
        argbuf_d    = argbuf_q;
        hi_d        = hi_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        pix_valid_d = 1'b0;
        pix_data_d  = pix_data_q;
        px_d        = px_q;
        py_d        = py_q;

        // Coordinates step the cycle after a pixel is reported
        if (pix_valid_q) begin
            if (px_q == xe_q) begin
                px_d = xs_q;
                py_d = (py_q == ye_q) ? ys_q : py_q + COORD_W'(1);
            end else begin
                px_d = px_q + COORD_W'(1);
            end
        end

        if (rx_valid) begin
            if (!rx_is_data) begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = rx_byte;
                arg_idx_d   = 2'd0;
                case (rx_byte)
                    CMD_CASET, CMD_RASET: state_d = ST_ARGS;
                    CMD_RAMWR: begin
                        state_d = ST_PIX_HI;
                        px_d    = xs_q;
                        py_d    = ys_q;
                    end
                    default: state_d = ST_SKIP;
                endcase
            end else begin
                case (state_q)
                    ST_ARGS: begin
                        arg_idx_d = arg_idx_q + 2'd1;
                        case (arg_idx_q)
                            2'd0: argbuf_d[23:16] = rx_byte;
                            2'd1: argbuf_d[15:8]  = rx_byte;
                            2'd2: argbuf_d[7:0]   = rx_byte;
                            default: begin
                                if (cmd_code_q == CMD_CASET) begin
                                    xs_d = COORD_W'(arg_start);
                                    xe_d = COORD_W'(arg_end);
                                end else begin
                                    ys_d = COORD_W'(arg_start);
                                    ye_d = COORD_W'(arg_end);
                                end
                                state_d = ST_SKIP;
                            end
                        endcase
                    end
                    ST_PIX_HI: begin
                        hi_d    = rx_byte;
                        state_d = ST_PIX_LO;
                    end
                    ST_PIX_LO: begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = pix_join(hi_q, rx_byte);
                        state_d     = ST_PIX_HI;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Decoder registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            arg_idx_q   <= '0;
            argbuf_q    <= '0;
            hi_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            xs_q        <= '0;
            xe_q        <= '1;
            ys_q        <= '0;
            ye_q        <= '1;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            px_q        <= '0;
            py_q        <= '0;
        end else begin
            state_q     <= state_d;
            arg_idx_q   <= arg_idx_d;
            argbuf_q    <= argbuf_d;
            hi_q        <= hi_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            px_q        <= px_d;
            py_q        <= py_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign x_start   = xs_q;
    assign x_end     = xe_q;
    assign y_start   = ys_q;
    assign y_end     = ye_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_x     = px_q;
    assign pix_y     = py_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: table of serial words with expected decoder
// events, plus hand sequences for latency, fragments and mid-byte reset.
module tb_lcd_spi_rx;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cs = 1'b1, dc = 1'b0, sclk = 1'b0, mosi = 1'b0;
    logic [8:0]  rx_data;
    logic        rx_valid, frag_err, cmd_valid, pix_valid;
    logic [7:0]  cmd_code, x_start, x_end, y_start, y_end, pix_x, pix_y;
    logic [15:0] pix_data;

    lcd_spi_rx #(
        .SYNC_STAGES(2),
        .COORD_W    (8)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cs       (cs),
        .dc       (dc),
        .sclk     (sclk),
        .mosi     (mosi),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frag_err (frag_err),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .x_start  (x_start),
        .x_end    (x_end),
        .y_start  (y_start),
        .y_end    (y_end),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .pix_x    (pix_x),
        .pix_y    (pix_y)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge
    int unsigned n_rx = 0, n_cmd = 0, n_pix = 0, n_frag = 0;
    int unsigned rx_cyc = 0, cmd_cyc = 0;
    logic [8:0]  last_rx = '0;
    logic [7:0]  last_cmd = '0, last_px = '0, last_py = '0;
    logic [15:0] last_pd = '0;
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (rx_valid)  begin n_rx++;  last_rx = rx_data; rx_cyc = cyc; end
            if (cmd_valid) begin n_cmd++; last_cmd = cmd_code; cmd_cyc = cyc; end
            if (pix_valid) begin n_pix++; last_pd = pix_data; last_px = pix_x; last_py = pix_y; end
            if (frag_err)  n_frag++;
        end
    end

    int unsigned nvec = 0, nerr = 0;
    int unsigned last_rise = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Clocks out nbits of b MSB first inside one CS frame (4 sys_clk per SCLK phase)
    task automatic send_bits(input logic d, input logic [7:0] b, input int nbits);
        tick(1);
        cs = 1'b0;
        dc = d;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            tick(4);
            sclk = 1'b1;
            last_rise = cyc;
            tick(4);
            sclk = 1'b0;
        end
        tick(2);
        cs = 1'b1;
        tick(6);
    endtask

    typedef struct {
        logic        d;
        logic [7:0]  b;
        logic        ec;
        logic        ep;
        logic [15:0] pd;
        logic [7:0]  px;
        logic [7:0]  py;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic d, input logic [7:0] b, input logic ec, input logic ep,
                       input logic [15:0] pd, input logic [7:0] px, input logic [7:0] py);
        vec_t v;
        v.d = d; v.b = b; v.ec = ec; v.ep = ep; v.pd = pd; v.px = px; v.py = py;
        tbl.push_back(v);
    endtask

    task automatic add_pix(input logic [7:0] px, input logic [7:0] py);
        add(1'b1, 8'hF8, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h00, 1'b0, 1'b1, 16'hF800, px, py);
    endtask

    int unsigned r0, c0, p0, f0;

    initial begin
        // Stimulus table
        add(1'b0, 8'h2A, 1'b1, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h02, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h05, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b0, 8'h2B, 1'b1, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h01, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h02, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b0, 8'h2C, 1'b1, 1'b0, 16'h0, 8'h0, 8'h0);
        add_pix(8'd2, 8'd1); add_pix(8'd3, 8'd1); add_pix(8'd4, 8'd1); add_pix(8'd5, 8'd1);
        add_pix(8'd2, 8'd2); add_pix(8'd3, 8'd2); add_pix(8'd4, 8'd2); add_pix(8'd5, 8'd2);
        add_pix(8'd2, 8'd1); add_pix(8'd3, 8'd1);
        // Pending high byte dropped by a command
        add(1'b1, 8'hAB, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b0, 8'h29, 1'b1, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h11, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h22, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        // Truncated CASET keeps the old x window
        add(1'b0, 8'h2A, 1'b1, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h09, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b0, 8'h2C, 1'b1, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h12, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
        add(1'b1, 8'h34, 1'b0, 1'b1, 16'h1234, 8'd2, 8'd1);

        // Reset state
        tick(4);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_strobes", 32'({rx_valid, frag_err, cmd_valid, pix_valid}), 32'h0);
        check("rst_cmd_code", 32'(cmd_code), 32'h0);
        check("rst_bounds", 32'({x_start, x_end, y_start, y_end}), 32'h00FF00FF);
        check("rst_pix", 32'({pix_data, pix_x, pix_y}), 32'h0);
        sys_rst = 1'b0;
        tick(4);

        // First word: strobe latency from the 8th SCLK rise
        r0 = n_rx; c0 = n_cmd;
        send_bits(1'b0, 8'h2A, 8);
        check("lat_rx_cnt", 32'(n_rx - r0), 32'd1);
        check("lat_rx_data", 32'(last_rx), 32'h02A);
        check("lat_rx_cycles", 32'(rx_cyc - last_rise), 32'd4);
        check("lat_cmd_cnt", 32'(n_cmd - c0), 32'd1);
        check("lat_cmd_code", 32'(last_cmd), 32'h2A);
        check("lat_cmd_cycles", 32'(cmd_cyc - last_rise), 32'd5);

        // Table-driven words
        for (int i = 0; i < tbl.size(); i++) begin
            r0 = n_rx; c0 = n_cmd; p0 = n_pix;
            send_bits(tbl[i].d, tbl[i].b, 8);
            check($sformatf("v%0d_rx_cnt", i), 32'(n_rx - r0), 32'd1);
            check($sformatf("v%0d_rx_data", i), 32'(last_rx), 32'({tbl[i].d, tbl[i].b}));
            check($sformatf("v%0d_cmd_cnt", i), 32'(n_cmd - c0), 32'(tbl[i].ec));
            if (tbl[i].ec)
                check($sformatf("v%0d_cmd_code", i), 32'(last_cmd), 32'(tbl[i].b));
            check($sformatf("v%0d_pix_cnt", i), 32'(n_pix - p0), 32'(tbl[i].ep));
            if (tbl[i].ep) begin
                check($sformatf("v%0d_pix_data", i), 32'(last_pd), 32'(tbl[i].pd));
                check($sformatf("v%0d_pix_xy", i), 32'({last_px, last_py}), 32'({tbl[i].px, tbl[i].py}));
            end
        end
        check("win_after_partial", 32'({x_start, x_end, y_start, y_end}), 32'h02050102);

        // Fragment: 5 bits then CS high, followed by a clean word
        r0 = n_rx; f0 = n_frag;
        send_bits(1'b1, 8'hFF, 5);
        check("frag_cnt", 32'(n_frag - f0), 32'd1);
        check("frag_no_rx", 32'(n_rx - r0), 32'd0);
        r0 = n_rx; f0 = n_frag;
        send_bits(1'b1, 8'h55, 8);
        check("after_frag_rx_cnt", 32'(n_rx - r0), 32'd1);
        check("after_frag_rx_data", 32'(last_rx), 32'h155);
        check("after_frag_no_frag", 32'(n_frag - f0), 32'd0);

        // Sync reset in the middle of a byte
        tick(1);
        cs = 1'b0; dc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mosi = i[0]; tick(4); sclk = 1'b1; tick(4); sclk = 1'b0;
        end
        sys_rst = 1'b1;
        tick(2);
        check("mid_rst_rx", 32'({rx_data, rx_valid, frag_err}), 32'h0);
        check("mid_rst_cmd", 32'({cmd_valid, cmd_code}), 32'h0);
        check("mid_rst_bounds", 32'({x_start, x_end, y_start, y_end}), 32'h00FF00FF);
        check("mid_rst_pix", 32'({pix_valid, pix_data, pix_x, pix_y}), 32'h0);
        sys_rst = 1'b0;
        tick(2);
        // CS stays low: a full byte must not be accepted until CS is seen high
        r0 = n_rx; f0 = n_frag;
        for (int i = 0; i < 8; i++) begin
            mosi = 1'b1; tick(4); sclk = 1'b1; tick(4); sclk = 1'b0;
        end
        tick(2); cs = 1'b1; tick(6);
        check("unarmed_no_rx", 32'(n_rx - r0), 32'd0);
        check("unarmed_no_frag", 32'(n_frag - f0), 32'd0);

        // Default full-screen window after reset
        c0 = n_cmd; p0 = n_pix;
        send_bits(1'b0, 8'h2C, 8);
        check("post_rst_cmd_cnt", 32'(n_cmd - c0), 32'd1);
        check("post_rst_cmd_code", 32'(last_cmd), 32'h2C);
        send_bits(1'b1, 8'hAA, 8);
        send_bits(1'b1, 8'hBB, 8);
        check("post_rst_pix_data", 32'(last_pd), 32'hAABB);
        check("post_rst_pix_xy0", 32'({last_px, last_py}), 32'h0000);
        send_bits(1'b1, 8'h01, 8);
        send_bits(1'b1, 8'h02, 8);
        check("post_rst_pix_cnt", 32'(n_pix - p0), 32'd2);
        check("post_rst_pix_xy1", 32'({last_px, last_py}), 32'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
